// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: forwarding codes, register-number width
// and the EX-stage bubble control record.
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_WB   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_NONE = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             wbEn;
    logic             isLoad;
    logic [REG_W-1:0] wbReg;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '{valid: 1'b0, wbEn: 1'b0, isLoad: 1'b0, wbReg: '0};

endpackage

// File: rtl/rd_ex_stage_fwd_mux.sv
// Three-way operand forwarding mux; code MSB selects the latched register
// value regardless of the LSB.
module fwd_mux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_wb,
  input  logic [WIDTH-1:0] i_mem,
  input  logic [WIDTH-1:0] i_reg,
  output logic [WIDTH-1:0] o_out
);

  always_comb begin
    o_out = i_wb;
    if (i_sel[1])      o_out = i_reg;
    else if (i_sel[0]) o_out = i_mem;
  end

endmodule

// File: rtl/rd_ex_stage.sv
// RD/EX pipeline register with EX-stage operand forwarding and the
// load-use interlock (one-cycle RD hold plus EX bubble).
module rd_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_valid,
  input  logic [4:0]       rd_rs,
  input  logic [4:0]       rd_rt,
  input  logic [WIDTH-1:0] rd_rsVal,
  input  logic [WIDTH-1:0] rd_rtVal,
  input  logic [4:0]       rd_wbReg,
  input  logic             rd_wbEn,
  input  logic             rd_isLoad,
  input  logic [1:0]       rd_fwdA,
  input  logic [1:0]       rd_fwdB,
  input  logic             stall_in,
  input  logic             flush,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [WIDTH-1:0] wb_result,
  output logic             stall_rd,
  output logic             ex_valid,
  output logic             ex_wbEn,
  output logic             ex_isLoad,
  output logic [4:0]       ex_wbReg,
  output logic [WIDTH-1:0] ex_opA,
  output logic [WIDTH-1:0] ex_opB
);

  ex_ctrl_t         r_ctrl;
  logic [1:0]       r_fwdA;
  logic [1:0]       r_fwdB;
  logic [WIDTH-1:0] r_rsVal;
  logic [WIDTH-1:0] r_rtVal;
  logic             w_luh;

  // $0 is hardwired to zero, so a load targeting it creates no dependency.
  always_comb begin
    w_luh = r_ctrl.valid & r_ctrl.isLoad & r_ctrl.wbEn & (r_ctrl.wbReg != '0) &
            rd_valid & ((rd_rs == r_ctrl.wbReg) | (rd_rt == r_ctrl.wbReg));
    stall_rd = stall_in | (w_luh & ~flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= EX_BUBBLE;
      r_fwdA  <= FWD_NONE;
      r_fwdB  <= FWD_NONE;
      r_rsVal <= '0;
      r_rtVal <= '0;
    end else if (stall_in) begin
      r_ctrl  <= r_ctrl;
    end else if (flush || w_luh) begin
      r_ctrl  <= EX_BUBBLE;
      r_fwdA  <= FWD_NONE;
      r_fwdB  <= FWD_NONE;
      r_rsVal <= '0;
      r_rtVal <= '0;
    end else begin
      r_ctrl.valid  <= rd_valid;
      r_ctrl.wbEn   <= rd_wbEn & rd_valid;
      r_ctrl.isLoad <= rd_isLoad;
      r_ctrl.wbReg  <= rd_wbReg;
      r_fwdA        <= rd_fwdA;
      r_fwdB        <= rd_fwdB;
      r_rsVal       <= rd_rsVal;
      r_rtVal       <= rd_rtVal;
    end
  end

  always_comb begin
    ex_valid  = r_ctrl.valid;
    ex_wbEn   = r_ctrl.wbEn;
    ex_isLoad = r_ctrl.isLoad;
    ex_wbReg  = r_ctrl.wbReg;
  end

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .i_sel (r_fwdA),
    .i_wb  (wb_result),
    .i_mem (mem_result),
    .i_reg (r_rsVal),
    .o_out (ex_opA)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .i_sel (r_fwdB),
    .i_wb  (wb_result),
    .i_mem (mem_result),
    .i_reg (r_rtVal),
    .o_out (ex_opB)
  );

endmodule

// File: doc/rd_ex_stage.md
# rd_ex_stage

Pipeline register between the register-read (RD) and execute (EX) stages of the MIPS core, plus the EX-stage operand forwarding muxes. It captures the RD-stage instruction's operand values, register numbers, writeback info and forwarding-control codes, then drives the ALU operands in EX. Sources are the latched register value, the MEM-stage result or the WB-stage result. It also implements the load-use interlock: the RD stage is held for one cycle and a bubble is injected into EX.

## Interface
- WIDTH, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_valid  in  1  RD holds a real instruction
- rd_rs, rd_rt  in  5  source register numbers read in RD
- rd_rsVal, rd_rtVal  in  WIDTH  register-file read data
- rd_wbReg  in  5  destination register
- rd_wbEn  in  1  instruction writes back
- rd_isLoad  in  1  instruction is a load
- rd_fwdA, rd_fwdB  in  2  forwarding codes for rs/rt, produced in RD by the forwarding control unit
- stall_in  in  1  global hold (memory stall)
- flush  in  1  squash the RD instruction (branch redirect)
- mem_result  in  WIDTH  result of the instruction now in MEM
- wb_result  in  WIDTH  result of the instruction now in WB
- stall_rd  out  1  hold PC and IF/RD register this cycle
- ex_valid, ex_wbEn, ex_isLoad  out  1  registered EX-stage control
- ex_wbReg  out  5  registered destination
- ex_opA, ex_opB  out  WIDTH  forwarded ALU operands

## Operation
- Forwarding code encoding:
  - 00: take wb_result.
  - 01: take mem_result.
  - 1x: take the latched rd_rsVal/rd_rtVal.
- Load-use hazard, combinational:
  - luh = ex_valid & ex_isLoad & ex_wbEn & (ex_wbReg != 0) & rd_valid & (rd_rs == ex_wbReg | rd_rt == ex_wbReg).
- stall_rd = stall_in | (luh & ~flush).
- Register update priority per rising edge:
  1. stall_in: all EX registers hold.
  2. flush: bubble.
  3. luh: bubble; the RD instruction is held by stall_rd and re-presented next cycle.
  4. Otherwise: capture all rd_* fields; ex_valid = rd_valid.
- Bubble contents:
  - ex_valid=0, ex_wbEn=0, ex_isLoad=0, ex_wbReg=0.
  - Forwarding codes = 10; operand values = 0.
- The forwarding codes are captured with the instruction. A held instruction keeps its codes.
- When the instruction is re-presented after a load-use bubble, the load sits in MEM. The RD forwarding unit then issues code 00, and the data is taken from wb_result one cycle later.
- Invalid instructions (rd_valid=0) are captured with wbEn forced to 0.
- Register $0: ex_wbReg==0 never triggers luh.

## Timing
- One cycle latency: RD inputs at edge n appear on ex_* after edge n.
- ex_opA/ex_opB are combinational from registered codes and values plus same-cycle mem_result/wb_result. There is no register on this path.
- stall_rd is combinational from RD inputs and EX registers. It must settle within the same cycle.
- Reset (async assert, sync release):
  - ex_valid=0, ex_wbEn=0, ex_isLoad=0, ex_wbReg=0.
  - Registered codes=10, registered values=0, so ex_opA=ex_opB=0.
  - stall_rd follows stall_in.
- Simultaneous events:
  - flush with luh: flush wins; stall_rd stays 0 because the RD instruction is discarded.
  - stall_in with flush or luh: hold wins; the flush must be re-asserted by its source after the stall.
- Back-to-back loads each feeding the next instruction produce exactly one bubble per load.
- Reset mid-stall clears EX to the bubble state immediately.

## Structure
- Shared package mips_pipe_pkg holds:
  - FWD_WB=2'b00, FWD_MEM=2'b01, FWD_NONE=2'b10;
  - the register-number width (5);
  - a bubble-constant record for EX control fields.
- Sub-module fwd_mux: three-input WIDTH-bit mux, selected by the 2-bit code with the MSB overriding. Instantiated twice, for opA and opB.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> ex_valid=0, ex_wbEn=0, ex_opA=ex_opB=0 immediately; after release, first rd_valid=1 instruction appears one edge later.
- Plain capture: rd_rsVal=0x1234, rd_rtVal=0xABCD, codes 10/10 -> next cycle ex_opA=0x1234, ex_opB=0xABCD.
- Forwarding: codes 01/00, mem_result=0x55, wb_result=0x66 -> ex_opA=0x55, ex_opB=0x66; changing mem_result to 0x77 in the same cycle -> ex_opA=0x77 combinationally.
- Load-use:
  - Stimulus: EX holds a load to $5; RD instruction reads rs=$5.
  - Expected: stall_rd=1 for one cycle and the next EX state is a bubble (ex_valid=0).
  - The re-presented instruction with code 00 then takes wb_result.
- Flush vs hazard: luh condition plus flush=1 -> stall_rd=0, EX bubble, and the next RD instruction is captured normally on the following edge.
- $0 and stall: load writing $0 with RD reading $0 -> no stall; stall_in=1 for 3 cycles -> all ex_* outputs constant throughout.
